// File: rtl/pkt_demux_if.sv
// Strobe-based packet stream bundle between port_0, the demux and the LCM/SSM inputs.
interface pkt_demux_if;
  // No ready: the sender writes a word on every cycle data_wr is high, and one
  // data_valid_wr strobe per packet carries data_valid on or after the tail word;
  // alf is advisory back-pressure the sender checks before starting a packet.
  logic [133:0] data;
  logic         data_wr;
  logic         data_valid;
  logic         data_valid_wr;
  logic         alf;

  modport master (output data, data_wr, data_valid, data_valid_wr, input alf);
  modport slave  (input data, data_wr, data_valid, data_valid_wr, output alf);
endinterface

// File: rtl/pkt_demux.sv
// Store-and-forward demux steering whole packets from port_0 to LCM or SSM.
// Optional packet counters are enabled with the DEMUX_STATS_EN macro.
module pkt_demux #(
  parameter int DATA_AW    = 8,
  parameter int VALID_AW   = 6,
  parameter int ALF_MARGIN = 160
) (
  input  logic        clk,
  input  logic        rst_n,
  pkt_demux_if.slave  rx_i,
  pkt_demux_if.master lcm_o,
  pkt_demux_if.master ssm_o,
  output logic [1:0]  state_o
`ifdef DEMUX_STATS_EN
  ,
  output logic [31:0] lcm_pkt_cnt,
  output logic [31:0] ssm_pkt_cnt,
  output logic [31:0] drop_pkt_cnt
`endif
);
  localparam int DATA_DEPTH  = 1 << DATA_AW;
  localparam int VALID_DEPTH = 1 << VALID_AW;
  localparam logic [DATA_AW:0]  D_ONE      = (DATA_AW+1)'(1);
  localparam logic [VALID_AW:0] V_ONE      = (VALID_AW+1)'(1);
  localparam logic [DATA_AW:0]  D_FULL_LVL = (DATA_AW+1)'(DATA_DEPTH);
  localparam logic [DATA_AW:0]  D_ALF_LVL  = (DATA_AW+1)'(DATA_DEPTH - ALF_MARGIN);
  localparam logic [VALID_AW:0] V_FULL_LVL = (VALID_AW+1)'(VALID_DEPTH);
  localparam logic [VALID_AW:0] V_ALF_LVL  = (VALID_AW+1)'(VALID_DEPTH - 2);
  localparam logic [1:0] TAG_HEAD = 2'b01;
  localparam logic [1:0] TAG_TAIL = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SEND_LCM = 2'd1,
    S_SEND_SSM = 2'd2,
    S_DISCARD  = 2'd3
  } state_e;

  state_e state_q;

  logic [133:0]      d_mem [DATA_DEPTH];
  logic              v_mem [VALID_DEPTH];
  logic [DATA_AW:0]  d_wr_q, d_rd_q, d_used;
  logic [VALID_AW:0] v_wr_q, v_rd_q, v_used;
  logic              d_push, d_pop, d_empty, d_full;
  logic              v_push, v_pop, v_empty, v_full;
  logic              alf_q;

  logic [133:0] head_word;
  logic         head_flag, head_is_head, head_is_tail, malformed;

  logic [133:0] lcm_data_q, ssm_data_q;
  logic         lcm_wr_q, lcm_vld_q, lcm_vwr_q;
  logic         ssm_wr_q, ssm_vld_q, ssm_vwr_q;

  assign d_used  = d_wr_q - d_rd_q;
  assign v_used  = v_wr_q - v_rd_q;
  assign d_empty = (d_used == '0);
  assign v_empty = (v_used == '0);
  assign d_full  = (d_used == D_FULL_LVL);
  assign v_full  = (v_used == V_FULL_LVL);
  assign d_push  = rx_i.data_wr && !d_full;
  assign v_push  = rx_i.data_valid_wr && !v_full;

  // Show-ahead heads: the FSM inspects the oldest word and flag before popping.
  assign head_word    = d_mem[d_rd_q[DATA_AW-1:0]];
  assign head_flag    = v_mem[v_rd_q[VALID_AW-1:0]];
  assign head_is_head = (head_word[133:132] == TAG_HEAD);
  assign head_is_tail = (head_word[133:132] == TAG_TAIL);

  always_comb begin
    d_pop     = 1'b0;
    v_pop     = 1'b0;
    malformed = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!v_empty && !d_empty && !head_is_head) begin
          d_pop     = 1'b1;
          malformed = 1'b1;
        end
      end
      S_SEND_LCM, S_SEND_SSM, S_DISCARD: begin
        if (!d_empty) begin
          d_pop = 1'b1;
          v_pop = head_is_tail;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (d_push) d_mem[d_wr_q[DATA_AW-1:0]] <= rx_i.data;
    if (v_push) v_mem[v_wr_q[VALID_AW-1:0]] <= rx_i.data_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_wr_q <= '0;
      d_rd_q <= '0;
      v_wr_q <= '0;
      v_rd_q <= '0;
      alf_q  <= 1'b0;
    end else begin
      if (d_push) d_wr_q <= d_wr_q + D_ONE;
      if (d_pop)  d_rd_q <= d_rd_q + D_ONE;
      if (v_push) v_wr_q <= v_wr_q + V_ONE;
      if (v_pop)  v_rd_q <= v_rd_q + V_ONE;
      alf_q <= (d_used >= D_ALF_LVL) || (v_used >= V_ALF_LVL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      lcm_data_q <= '0;
      lcm_wr_q   <= 1'b0;
      lcm_vld_q  <= 1'b0;
      lcm_vwr_q  <= 1'b0;
      ssm_data_q <= '0;
      ssm_wr_q   <= 1'b0;
      ssm_vld_q  <= 1'b0;
      ssm_vwr_q  <= 1'b0;
    end else begin
      lcm_data_q <= '0;
      lcm_wr_q   <= 1'b0;
      lcm_vld_q  <= 1'b0;
      lcm_vwr_q  <= 1'b0;
      ssm_data_q <= '0;
      ssm_wr_q   <= 1'b0;
      ssm_vld_q  <= 1'b0;
      ssm_vwr_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // A blocked head packet holds everything behind it; no bypass.
          if (!v_empty && !d_empty && head_is_head) begin
            if (!head_flag)                      state_q <= S_DISCARD;
            else if (head_word[127] && !lcm_o.alf)  state_q <= S_SEND_LCM;
            else if (!head_word[127] && !ssm_o.alf) state_q <= S_SEND_SSM;
          end
        end
        S_SEND_LCM: begin
          if (!d_empty) begin
            lcm_data_q <= head_word;
            lcm_wr_q   <= 1'b1;
            if (head_is_tail) begin
              lcm_vwr_q <= 1'b1;
              lcm_vld_q <= head_flag;
              state_q   <= S_IDLE;
            end
          end
        end
        S_SEND_SSM: begin
          if (!d_empty) begin
            ssm_data_q <= head_word;
            ssm_wr_q   <= 1'b1;
            if (head_is_tail) begin
              ssm_vwr_q <= 1'b1;
              ssm_vld_q <= head_flag;
              state_q   <= S_IDLE;
            end
          end
        end
        S_DISCARD: begin
          if (!d_empty && head_is_tail) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef DEMUX_STATS_EN
  logic [31:0] lcm_cnt_q, ssm_cnt_q, drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcm_cnt_q  <= '0;
      ssm_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (state_q == S_SEND_LCM && d_pop && head_is_tail) lcm_cnt_q <= lcm_cnt_q + 32'd1;
      if (state_q == S_SEND_SSM && d_pop && head_is_tail) ssm_cnt_q <= ssm_cnt_q + 32'd1;
      if ((state_q == S_DISCARD && d_pop && head_is_tail) || malformed)
        drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

  assign lcm_pkt_cnt  = lcm_cnt_q;
  assign ssm_pkt_cnt  = ssm_cnt_q;
  assign drop_pkt_cnt = drop_cnt_q;
`endif

  assign rx_i.alf            = alf_q;
  assign lcm_o.data          = lcm_data_q;
  assign lcm_o.data_wr       = lcm_wr_q;
  assign lcm_o.data_valid    = lcm_vld_q;
  assign lcm_o.data_valid_wr = lcm_vwr_q;
  assign ssm_o.data          = ssm_data_q;
  assign ssm_o.data_wr       = ssm_wr_q;
  assign ssm_o.data_valid    = ssm_vld_q;
  assign ssm_o.data_valid_wr = ssm_vwr_q;
  assign state_o             = state_q;
endmodule

// File: tb/tb_pkt_demux.sv
// Bench for pkt_demux: directed latency/boundary cases plus randomized packet traffic
// checked against a packet-level model of where each good packet must appear.
module tb_pkt_demux;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] state_dbg;
  always #5 clk = ~clk;

  pkt_demux_if rx_if ();
  pkt_demux_if lcm_if ();
  pkt_demux_if ssm_if ();

`ifdef DEMUX_STATS_EN
  logic [31:0] lcm_pkt_cnt, ssm_pkt_cnt, drop_pkt_cnt;
`endif

  pkt_demux dut (
    .clk(clk), .rst_n(rst_n), .rx_i(rx_if), .lcm_o(lcm_if), .ssm_o(ssm_if), .state_o(state_dbg)
`ifdef DEMUX_STATS_EN
    , .lcm_pkt_cnt(lcm_pkt_cnt), .ssm_pkt_cnt(ssm_pkt_cnt), .drop_pkt_cnt(drop_pkt_cnt)
`endif
  );

  logic rand_en = 1'b0, lcm_alf_dir = 1'b0, ssm_alf_dir = 1'b0, lcm_rand = 1'b0, ssm_rand = 1'b0;
  assign lcm_if.alf = rand_en ? lcm_rand : lcm_alf_dir;
  assign ssm_if.alf = rand_en ? ssm_rand : ssm_alf_dir;

  int errors = 0, checks = 0, cyc = 0;
  int m_lcm = 0, m_ssm = 0, m_drop = 0;
  logic [133:0] exp_lcm_q [$];
  logic [133:0] exp_ssm_q [$];
  bit           order_q [$];
  logic [133:0] pkt_w [$];
  int words [2], head_cyc [2], tail_cyc [2];
  bit in_pkt [2];
  logic [1:0] alf_h1 = '0, alf_h2 = '0;

  task automatic chk(input string name, input logic [133:0] act, input logic [133:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_word(input logic [133:0] w, input logic vwr, input logic vflag);
    rx_if.data = w; rx_if.data_wr = 1'b1;
    rx_if.data_valid_wr = vwr; rx_if.data_valid = vwr & vflag;
    @(posedge clk); #1;
    rx_if.data = '0; rx_if.data_wr = 1'b0; rx_if.data_valid_wr = 1'b0; rx_if.data_valid = 1'b0;
  endtask

  task automatic push_valid(input logic vflag);
    rx_if.data_valid_wr = 1'b1; rx_if.data_valid = vflag;
    @(posedge clk); #1;
    rx_if.data_valid_wr = 1'b0; rx_if.data_valid = 1'b0;
  endtask

  // Reference model: a good packet goes whole to its destination, in arrival order.
  task automatic model_accept(input bit to_lcm, input bit flag);
    if (!flag) m_drop++;
    else begin
      foreach (pkt_w[i]) begin
        if (to_lcm) exp_lcm_q.push_back(pkt_w[i]);
        else        exp_ssm_q.push_back(pkt_w[i]);
      end
      order_q.push_back(to_lcm);
      if (to_lcm) m_lcm++; else m_ssm++;
    end
  endtask

  task automatic model_clear();
    exp_lcm_q.delete(); exp_ssm_q.delete(); order_q.delete();
    m_lcm = 0; m_ssm = 0; m_drop = 0;
  endtask

  task automatic send_built(input bit to_lcm, input bit flag, input int vdly);
    foreach (pkt_w[i]) begin
      if (i == pkt_w.size() - 1 && vdly == 0) begin
        model_accept(to_lcm, flag);
        push_word(pkt_w[i], 1'b1, flag);
      end else push_word(pkt_w[i], 1'b0, 1'b0);
    end
    if (vdly > 0) begin
      idle_cycles(vdly - 1);
      model_accept(to_lcm, flag);
      push_valid(flag);
    end
  endtask

  task automatic build_fixed(input bit to_lcm);
    pkt_w.delete();
    pkt_w.push_back({2'b01, 4'hf, to_lcm, 127'h0a1});
    pkt_w.push_back({2'b11, 4'hf, 128'h11111111_11111111_11111111_11111111});
    pkt_w.push_back({2'b11, 4'hf, 128'h22222222_22222222_22222222_22222222});
    pkt_w.push_back({2'b11, 4'hf, 128'h0023cd76631a002185c52b8f08004500});
    pkt_w.push_back({2'b11, 4'hf, 128'h44444444_44444444_44444444_44444444});
    pkt_w.push_back({2'b10, 4'h6, 128'h55555555_55555555_55555555_55555555});
  endtask

  task automatic send_rand();
    int len, vdly;
    bit to_lcm, flag;
    len    = $urandom_range(2, 12);
    to_lcm = 1'($urandom_range(0, 1));
    flag   = ($urandom_range(0, 9) != 0);
    vdly   = $urandom_range(0, 3);
    if ($urandom_range(0, 7) == 0) begin
      push_word({2'b11, 4'h0, $urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, 1'b0);
      m_drop++;
    end
    pkt_w.delete();
    for (int i = 0; i < len; i++) begin
      logic [127:0] p;
      logic [1:0]   tag;
      p = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (i == 0) p[127] = to_lcm;
      tag = (i == 0) ? 2'b01 : (i == len - 1) ? 2'b10 : 2'b11;
      pkt_w.push_back({tag, 4'($urandom_range(0, 15)), p});
    end
    send_built(to_lcm, flag, vdly);
    idle_cycles($urandom_range(0, 2));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    idle_cycles(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input int budget, input string nm);
    int n;
    n = 0;
    while ((exp_lcm_q.size() != 0 || exp_ssm_q.size() != 0) && n < budget) begin
      idle_cycles(1);
      n++;
    end
    idle_cycles(3);
    chk({nm, "_drained"}, 134'(exp_lcm_q.size() + exp_ssm_q.size()), 134'd0);
  endtask

  task automatic check_latency(input bit on_lcm, input logic [133:0] head_lit, input string nm);
    logic [133:0] d;
    logic wr, v, vwr, other_wr;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (on_lcm) begin d = lcm_if.data; wr = lcm_if.data_wr; v = lcm_if.data_valid; vwr = lcm_if.data_valid_wr; other_wr = ssm_if.data_wr; end
      else begin d = ssm_if.data; wr = ssm_if.data_wr; v = ssm_if.data_valid; vwr = ssm_if.data_valid_wr; other_wr = lcm_if.data_wr; end
      if (k < 2) chk({nm, "_early_wr"}, wr, 1'b0);
      else if (k == 2) begin
        chk({nm, "_head_wr"}, wr, 1'b1);
        chk({nm, "_head_word"}, d, head_lit);
      end else if (k == 5) chk({nm, "_word3"}, d, {2'b11, 4'hf, 128'h0023cd76631a002185c52b8f08004500});
      else if (k == 7) begin
        chk({nm, "_tail_strobes"}, {wr, v, vwr}, 3'b111);
        chk({nm, "_other_port_wr"}, other_wr, 1'b0);
      end
    end
  endtask

  // ---------------- scoreboard / compare process ----------------
  task automatic mon_port(input int s, input logic [133:0] d, input logic wr, input logic v,
                          input logic vwr, input logic alf_old);
    logic [133:0] e;
    bit tl;
    string pn;
    pn = (s == 1) ? "lcm" : "ssm";
    if (!wr) begin
      chk({pn, "_contiguous"}, in_pkt[s], 1'b0);
      chk({pn, "_idle_bus"}, {d, v, vwr}, '0);
    end else if ((s == 1 && exp_lcm_q.size() == 0) || (s == 0 && exp_ssm_q.size() == 0)) begin
      checks++; errors++;
      $display("FAIL %s_unexpected_word actual=%h expected=none", pn, d);
    end else begin
      if (s == 1) e = exp_lcm_q.pop_front();
      else        e = exp_ssm_q.pop_front();
      tl = (e[133:132] == 2'b10);
      chk({pn, "_word"}, d, e);
      chk({pn, "_valid_strobes"}, {v, vwr}, tl ? 2'b11 : 2'b00);
      if (e[133:132] == 2'b01) begin
        checks++;
        if (order_q.size() == 0 || order_q[0] != s[0]) begin
          errors++;
          $display("FAIL %s_packet_order actual=%0d expected_front=%0d", pn, s,
                   order_q.size() ? int'(order_q[0]) : -1);
        end
        if (order_q.size() != 0) void'(order_q.pop_front());
        chk({pn, "_started_under_alf"}, alf_old, 1'b0);
        head_cyc[s] = cyc;
      end
      in_pkt[s] = !tl;
      if (tl) tail_cyc[s] = cyc;
      words[s]++;
    end
  endtask

  initial begin : compare_proc
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        in_pkt[0] = 1'b0; in_pkt[1] = 1'b0;
        alf_h1 = '0; alf_h2 = '0;
      end else begin
        mon_port(1, lcm_if.data, lcm_if.data_wr, lcm_if.data_valid, lcm_if.data_valid_wr, alf_h2[1]);
        mon_port(0, ssm_if.data, ssm_if.data_wr, ssm_if.data_valid, ssm_if.data_valid_wr, alf_h2[0]);
        alf_h2 = alf_h1;
        alf_h1 = {lcm_if.alf, ssm_if.alf};
      end
    end
  end

  initial begin : rand_alf_gen
    forever begin
      @(posedge clk); #1;
      lcm_rand = ($urandom_range(0, 3) == 0);
      ssm_rand = ($urandom_range(0, 3) == 0);
    end
  end

  initial begin : watchdog
    #3000000;
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main_seq
    int w0, n;
    rx_if.data = '0; rx_if.data_wr = 1'b0; rx_if.data_valid = 1'b0; rx_if.data_valid_wr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_lcm_bus", {lcm_if.data, lcm_if.data_wr, lcm_if.data_valid, lcm_if.data_valid_wr}, '0);
    chk("reset_ssm_bus", {ssm_if.data, ssm_if.data_wr, ssm_if.data_valid, ssm_if.data_valid_wr}, '0);
    chk("reset_rx_alf", rx_if.alf, 1'b0);
    chk("reset_state", state_dbg, 2'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_cycles(2);

    build_fixed(1'b1);
    send_built(1'b1, 1'b1, 1);
    check_latency(1'b1, {2'b01, 4'hf, 128'h80000000_00000000_00000000_000000a1}, "lcm_pkt");
    idle_cycles(2);

    build_fixed(1'b0);
    send_built(1'b0, 1'b1, 1);
    check_latency(1'b0, {2'b01, 4'hf, 128'h00000000_00000000_00000000_000000a1}, "ssm_pkt");
    idle_cycles(2);

    w0 = words[0] + words[1];
    build_fixed(1'b1);
    send_built(1'b1, 1'b0, 1);
    idle_cycles(8);
    chk("discard_no_output", 134'(words[0] + words[1] - w0), 134'd0);
    chk("discard_back_to_idle", state_dbg, 2'd0);

    lcm_alf_dir = 1'b1;
    w0 = words[0] + words[1];
    build_fixed(1'b1); send_built(1'b1, 1'b1, 0);
    build_fixed(1'b0); send_built(1'b0, 1'b1, 0);
    idle_cycles(15);
    chk("alf_holds_head", 134'(words[0] + words[1] - w0), 134'd0);
    lcm_alf_dir = 1'b0;
    wait_drain(80, "alf_release");
    chk("back_to_back_gap", 134'(head_cyc[0] - tail_cyc[1]), 134'd2);

    // Data FIFO: threshold at 256-160=96 words, then overflow beyond 256.
    do_reset();
    pkt_w.delete();
    for (int i = 0; i < 256; i++) begin
      logic [1:0] tag;
      tag = (i == 0) ? 2'b01 : (i == 255) ? 2'b10 : 2'b11;
      pkt_w.push_back({tag, 4'hf, (i == 0), 127'(i + 32'h1000)});
    end
    foreach (pkt_w[i]) begin
      push_word(pkt_w[i], 1'b0, 1'b0);
      if (i == 94) chk("alf_below_thr", rx_if.alf, 1'b0);
      if (i == 95) chk("alf_at_96_same_cycle", rx_if.alf, 1'b0);
      if (i == 96) chk("alf_cycle_after_96", rx_if.alf, 1'b1);
    end
    for (int i = 0; i < 8; i++) push_word({2'b11, 4'h0, 128'(32'hdead0000 + i)}, 1'b0, 1'b0);
    chk("alf_when_full", rx_if.alf, 1'b1);
    chk("full_no_output", 134'(lcm_if.data_wr | ssm_if.data_wr), 134'd0);
    model_accept(1'b1, 1'b1);
    push_valid(1'b1);
    wait_drain(700, "full_packet");

    // Validity FIFO: threshold at 64-2=62 flags.
    do_reset();
    for (int i = 0; i < 62; i++) push_valid(1'b0);
    chk("valid_alf_before", rx_if.alf, 1'b0);
    idle_cycles(1);
    chk("valid_alf_at_62", rx_if.alf, 1'b1);

    // Reset in the middle of an LCM send.
    do_reset();
    build_fixed(1'b1);
    send_built(1'b1, 1'b1, 1);
    w0 = words[1]; n = 0;
    while (words[1] - w0 < 4 && n < 40) begin @(negedge clk); #1; n++; end
    chk("reset_reached_word3", 134'(words[1] - w0), 134'd4);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_lcm_bus", {lcm_if.data, lcm_if.data_wr, lcm_if.data_valid, lcm_if.data_valid_wr}, '0);
    chk("midreset_state", state_dbg, 2'd0);
    model_clear();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    w0 = words[0];
    build_fixed(1'b0);
    send_built(1'b0, 1'b1, 2);
    wait_drain(60, "post_reset");
    chk("post_reset_ssm_words", 134'(words[0] - w0), 134'd6);

    // Randomized traffic with random destination back-pressure.
    rand_en = 1'b1;
    for (int p = 0; p < 40; p++) begin
      n = 0;
      while (rx_if.alf && n < 3000) begin idle_cycles(1); n++; end
      if (n >= 3000) begin
        checks++; errors++;
        $display("FAIL rx_alf_timeout actual=1 expected=0");
      end
      send_rand();
    end
    rand_en = 1'b0;
    wait_drain(3000, "random");
    idle_cycles(40);
    chk("final_state_idle", state_dbg, 2'd0);
`ifdef DEMUX_STATS_EN
    chk("stat_lcm", lcm_pkt_cnt, 134'(m_lcm));
    chk("stat_ssm", ssm_pkt_cnt, 134'(m_ssm));
    chk("stat_drop", drop_pkt_cnt, 134'(m_drop));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
